// File: rtl/aes_pkg.sv
// Shared definitions for the block-cipher mode engine: mode codes, FSM states,
// default widths and the core-input select used by the chaining datapath.
package aes_pkg;
    localparam int BLK_S_DEF   = 128;
    localparam int IV_BITS_DEF = BLK_S_DEF;
    localparam int CTR_W_DEF   = 32;

    localparam logic [2:0] MODE_ECB  = 3'd0;
    localparam logic [2:0] MODE_CBC  = 3'd1;
    localparam logic [2:0] MODE_PCBC = 3'd2;
    localparam logic [2:0] MODE_CFB  = 3'd3;
    localparam logic [2:0] MODE_OFB  = 3'd4;
    localparam logic [2:0] MODE_CTR  = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_CORE_REQ, ST_CORE_WAIT, ST_OUT} state_t;

    // What the core is fed with: the block, the block xor IV, or the IV alone.
    typedef enum logic [1:0] {CSEL_X, CSEL_XI, CSEL_I} csel_t;

    function automatic logic mode_legal(input logic [2:0] m);
        return m <= MODE_CTR;
    endfunction
endpackage

// File: rtl/aes_chain_unit_if.sv
// Config, stream and AES-core handshake bundle for aes_chain_unit.
interface aes_chain_unit_if import aes_pkg::*; #(parameter int BLK_S = BLK_S_DEF);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_mode;
    logic             cfg_encrypt;
    logic [BLK_S-1:0] cfg_iv;
    logic             s_valid;
    logic             s_ready;
    logic [BLK_S-1:0] s_data;
    logic             core_in_valid;
    logic             core_in_ready;
    logic [BLK_S-1:0] core_in_data;
    logic             core_encrypt;
    logic             core_out_valid;
    logic             core_out_ready;
    logic [BLK_S-1:0] core_out_data;
    logic             m_valid;
    logic             m_ready;
    logic [BLK_S-1:0] m_data;
    logic             mode_err;

    modport slave (
        input  cfg_valid, cfg_mode, cfg_encrypt, cfg_iv, s_valid, s_data,
               core_in_ready, core_out_valid, core_out_data, m_ready,
        output cfg_ready, s_ready, core_in_valid, core_in_data, core_encrypt,
               core_out_ready, m_valid, m_data, mode_err
    );
    modport master (
        output cfg_valid, cfg_mode, cfg_encrypt, cfg_iv, s_valid, s_data,
               core_in_ready, core_out_valid, core_out_data, m_ready,
        input  cfg_ready, s_ready, core_in_valid, core_in_data, core_encrypt,
               core_out_ready, m_valid, m_data, mode_err
    );
endinterface

// File: rtl/chain_xor.sv
// Combinational chaining equations: core-input select, output block and next IV
// for each cipher mode. X = latched input block, Y = core result, I = IV.
module chain_xor import aes_pkg::*; #(
    parameter int BLK_S = IV_BITS_DEF,
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic [2:0]       mode,
    input  logic             encrypt,
    input  logic [BLK_S-1:0] x,
    input  logic [BLK_S-1:0] y,
    input  logic [BLK_S-1:0] iv,
    output csel_t            csel,
    output logic             core_enc,
    output logic [BLK_S-1:0] out,
    output logic [BLK_S-1:0] iv_next
);
    always_comb begin
        csel     = CSEL_X;
        core_enc = encrypt;
        out      = y;
        iv_next  = iv;
        case (mode)
            MODE_CBC: begin
                csel    = encrypt ? CSEL_XI : CSEL_X;
                out     = encrypt ? y : y ^ iv;
                iv_next = encrypt ? y : x;
            end
            MODE_PCBC: begin
                csel    = encrypt ? CSEL_XI : CSEL_X;
                out     = encrypt ? y : y ^ iv;
                iv_next = encrypt ? x ^ y : x ^ y ^ iv;
            end
            // Stream modes always run the core forwards on the IV.
            MODE_CFB: begin
                csel     = CSEL_I;
                core_enc = 1'b1;
                out      = y ^ x;
                iv_next  = encrypt ? y ^ x : x;
            end
            MODE_OFB: begin
                csel     = CSEL_I;
                core_enc = 1'b1;
                out      = y ^ x;
                iv_next  = y;
            end
            MODE_CTR: begin
                csel     = CSEL_I;
                core_enc = 1'b1;
                out      = y ^ x;
                iv_next  = {iv[BLK_S-1:CTR_W], iv[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1}};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/aes_chain_unit.sv
// Multi-mode block-cipher chaining engine with one block in flight between the
// stream path and the AES core; owns the IV register and the core handshake.
module aes_chain_unit import aes_pkg::*; #(
    parameter int BLK_S = BLK_S_DEF,
    parameter int CTR_W = CTR_W_DEF
) (
    input logic          clk,
    input logic          reset,
    aes_chain_unit_if.slave bus
);
    localparam int IV_BITS = BLK_S;

    state_t             state;
    logic [2:0]         mode_q;
    logic               enc_q;
    logic [IV_BITS-1:0] iv_q;
    logic [BLK_S-1:0]   in_q;
    logic [BLK_S-1:0]   core_d;
    logic [BLK_S-1:0]   m_d;
    logic               err_q;
    logic               cfg_rdy;
    logic               cin_vld;
    logic               cout_rdy;
    logic               m_vld;

    csel_t              csel;
    logic               core_enc;
    logic [BLK_S-1:0]   out_nxt;
    logic [BLK_S-1:0]   iv_nxt;

    chain_xor #(.BLK_S(BLK_S), .CTR_W(CTR_W)) u_xor (
        .mode     (mode_q),
        .encrypt  (enc_q),
        .x        (in_q),
        .y        (bus.core_out_data),
        .iv       (iv_q),
        .csel     (csel),
        .core_enc (core_enc),
        .out      (out_nxt),
        .iv_next  (iv_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_ECB;
            enc_q    <= 1'b1;
            iv_q     <= '0;
            in_q     <= '0;
            core_d   <= '0;
            m_d      <= '0;
            err_q    <= 1'b0;
            cfg_rdy  <= 1'b1;
            cin_vld  <= 1'b0;
            cout_rdy <= 1'b0;
            m_vld    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Config wins over data when both are offered.
                    if (bus.cfg_valid) begin
                        mode_q <= mode_legal(bus.cfg_mode) ? bus.cfg_mode : MODE_ECB;
                        if (!mode_legal(bus.cfg_mode)) err_q <= 1'b1;
                        enc_q  <= bus.cfg_encrypt;
                        iv_q   <= bus.cfg_iv;
                    end else if (bus.s_valid) begin
                        in_q <= bus.s_data;
                        case (csel)
                            CSEL_XI: core_d <= bus.s_data ^ iv_q;
                            CSEL_I:  core_d <= iv_q;
                            default: core_d <= bus.s_data;
                        endcase
                        state   <= ST_CORE_REQ;
                        cfg_rdy <= 1'b0;
                        cin_vld <= 1'b1;
                    end
                end
                ST_CORE_REQ: if (bus.core_in_ready) begin
                    state    <= ST_CORE_WAIT;
                    cin_vld  <= 1'b0;
                    cout_rdy <= 1'b1;
                end
                ST_CORE_WAIT: if (bus.core_out_valid) begin
                    m_d      <= out_nxt;
                    iv_q     <= iv_nxt;
                    state    <= ST_OUT;
                    cout_rdy <= 1'b0;
                    m_vld    <= 1'b1;
                end
                ST_OUT: if (bus.m_ready) begin
                    state   <= ST_IDLE;
                    m_vld   <= 1'b0;
                    cfg_rdy <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready      = cfg_rdy;
    assign bus.s_ready        = cfg_rdy & ~bus.cfg_valid;
    assign bus.core_in_valid  = cin_vld;
    assign bus.core_in_data   = core_d;
    assign bus.core_encrypt   = core_enc;
    assign bus.core_out_ready = cout_rdy;
    assign bus.m_valid        = m_vld;
    assign bus.m_data         = m_d;
    assign bus.mode_err       = err_q;
endmodule

// File: tb/tb_aes_chain_unit.sv
// Bench for aes_chain_unit: a behavioural AES-128 / stub core responder, a
// textbook mode-equation model, vector table, corner sequences and random runs.
module tb_aes_chain_unit;
    import aes_pkg::*;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A5  = {16{8'ha5}};
    localparam logic [127:0] K3C = {16{8'h3c}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_chain_unit_if #(.BLK_S(128)) bus();
    aes_chain_unit #(.BLK_S(128), .CTR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0, n_s = 0, n_cin = 0, n_cout = 0, n_m = 0;
    int stab_err = 0, ci_stall = 0, core_lat = 0;
    bit aes_real = 0, abort = 0;
    logic [127:0] cin_q[$];
    bit           cenc_q[$];
    logic [7:0]   sbox[256];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.s_valid && bus.s_ready) n_s <= n_s + 1;
        if (bus.core_in_valid && bus.core_in_ready) n_cin <= n_cin + 1;
        if (bus.core_out_valid && bus.core_out_ready) n_cout <= n_cout + 1;
        if (bus.m_valid && bus.m_ready) n_m <= n_m + 1;
    end

    // ---------------- behavioural AES-128 encrypt ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a0, input logic [7:0] b0);
        logic [7:0] a = a0, b = b0, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv; r = inv;
            for (int k = 0; k < 4; k++) begin r = {r[6:0], r[7]}; s ^= r; end
            sbox[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w[44];
        logic [31:0] tw;
        logic [7:0]  b[16], t[16], rc, a0, a1, a2, a3;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox[tw[31:24]], sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // Stub cipher: direction-dependent so the core_encrypt line is observable.
    function automatic logic [127:0] stub(input logic [127:0] x, input bit e);
        return e ? x ^ A5 : x ^ K3C;
    endfunction

    // Textbook mode equations over cipher E/D; iv is the running chaining value.
    task automatic model(input logic [2:0] m, input bit e, inout logic [127:0] iv,
                         input logic [127:0] x, output logic [127:0] out,
                         output logic [127:0] cin, output bit ce);
        logic [127:0] ks;
        ce = 1'b1;
        case (m)
            MODE_CBC: if (e) begin cin = x ^ iv; out = stub(cin, 1); iv = out; end
                      else begin cin = x; ce = 0; out = stub(x, 0) ^ iv; iv = x; end
            MODE_PCBC: if (e) begin cin = x ^ iv; out = stub(cin, 1); iv = x ^ out; end
                       else begin cin = x; ce = 0; out = stub(x, 0) ^ iv; iv = x ^ out; end
            MODE_CFB: begin cin = iv; out = stub(iv, 1) ^ x; iv = e ? out : x; end
            MODE_OFB: begin cin = iv; ks = stub(iv, 1); out = ks ^ x; iv = ks; end
            MODE_CTR: begin cin = iv; out = stub(iv, 1) ^ x; iv = {iv[127:32], iv[31:0] + 32'd1}; end
            default:  begin cin = x; ce = e; out = stub(x, e); end
        endcase
    endtask

    // ---------------- core responder ----------------
    initial begin
        bus.core_in_ready = 0; bus.core_out_valid = 0; bus.core_out_data = '0;
        forever begin
            logic [127:0] cap;
            bit ce;
            @(negedge clk);
            if (bus.core_in_valid) begin
                cap = bus.core_in_data; ce = bus.core_encrypt;
                repeat (ci_stall) begin
                    @(negedge clk);
                    if (bus.core_in_data !== cap || !bus.core_in_valid) stab_err++;
                end
                bus.core_in_ready = 1;
                @(posedge clk);
                @(negedge clk);
                bus.core_in_ready = 0;
                cin_q.push_back(cap); cenc_q.push_back(ce);
                repeat (core_lat) @(negedge clk);
                bus.core_out_data  = aes_real ? aes_enc(KEY, cap) : stub(cap, ce);
                bus.core_out_valid = 1;
                while (!bus.core_out_ready && !abort) @(negedge clk);
                if (abort) repeat (3) @(negedge clk);
                else begin @(posedge clk); @(negedge clk); end
                bus.core_out_valid = 0;
            end
        end
    end

    // ---------------- host-side tasks ----------------
    task automatic do_cfg(input logic [2:0] m, input bit e, input logic [127:0] iv);
        int t;
        @(negedge clk);
        bus.cfg_valid = 1; bus.cfg_mode = m; bus.cfg_encrypt = e; bus.cfg_iv = iv;
        t = 0;
        while (!bus.cfg_ready && t < 100) begin @(negedge clk); t++; end
        if (!bus.cfg_ready) chk("cfg_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 0;
    endtask

    task automatic run_block(input logic [127:0] x, input int m_hold,
                             output logic [127:0] got, output int lat);
        int t, t0;
        logic [127:0] held;
        @(negedge clk);
        bus.s_valid = 1; bus.s_data = x;
        t = 0;
        while (!bus.s_ready && t < 100) begin @(negedge clk); t++; end
        if (!bus.s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        t0 = cyc; bus.s_valid = 0;
        t = 0;
        while (!bus.m_valid && t < 200) begin @(negedge clk); t++; end
        if (!bus.m_valid) chk("m_valid_timeout", 0, 1);
        got = bus.m_data; held = got;
        repeat (m_hold) begin
            @(negedge clk);
            if (bus.m_data !== held || !bus.m_valid) stab_err++;
        end
        bus.m_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.m_ready = 0;
        lat = cyc - t0;
    endtask

    typedef struct {
        bit           load;
        logic [2:0]   mode;
        bit           enc;
        logic [127:0] iv;
        bit           real_aes;
        logic [127:0] x;
        logic [127:0] exp_out;
        logic [127:0] exp_iv;
        logic [127:0] exp_cin;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [127:0] got, miv, eo, ec, x, riv;
        bit ece, mv;
        int lat, lat0, s0, ci0, co0, m0, st0;
        logic [127:0] ctr0;

        bus.cfg_valid = 0; bus.cfg_mode = 0; bus.cfg_encrypt = 0; bus.cfg_iv = '0;
        bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;
        init_sbox();

        #12;
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_core_in_valid", bus.core_in_valid, 0);
        chk("rst_core_out_ready", bus.core_out_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_mode_err", bus.mode_err, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_core_in_data", bus.core_in_data, 0);
        chk("rst_core_encrypt", bus.core_encrypt, 1);
        @(negedge clk);
        reset = 0;

        // ---- vector table ----
        ctr0 = {96'h1, 32'hffffffff};
        vt[0] = '{1, MODE_CBC, 1, 128'h000102030405060708090a0b0c0d0e0f, 1,
                  128'h6bc1bee22e409f96e93d7e117393172a,
                  128'h7649abac8119b246cee98e9b12e9197d,
                  128'h7649abac8119b246cee98e9b12e9197d,
                  128'h6bc1bee22e409f96e93d7e117393172a ^ 128'h000102030405060708090a0b0c0d0e0f};
        vt[1] = '{1, MODE_PCBC, 1, 128'h0, 0, {16{8'h11}}, {16{8'hb4}}, A5, {16{8'h11}}};
        vt[2] = '{0, MODE_PCBC, 1, 128'h0, 0, {16{8'h11}}, {16{8'h11}}, 128'h0, {16{8'hb4}}};
        vt[3] = '{1, MODE_CTR, 1, ctr0, 0, 128'h0, ctr0 ^ A5, {96'h1, 32'h0}, ctr0};
        vt[4] = '{0, MODE_CTR, 1, 128'h0, 0, 128'h0, {96'h1, 32'h0} ^ A5,
                  {96'h1, 32'h1}, {96'h1, 32'h0}};
        vt[5] = '{0, MODE_CTR, 1, 128'h0, 0, 128'h0, {96'h1, 32'h1} ^ A5,
                  {96'h1, 32'h2}, {96'h1, 32'h1}};
        vt[6] = '{1, 3'd7, 1, 128'hdeadbeef_00000000_cafef00d_12345678, 0,
                  128'h0123456789abcdef0011223344556677,
                  128'h0123456789abcdef0011223344556677 ^ A5,
                  128'hdeadbeef_00000000_cafef00d_12345678,
                  128'h0123456789abcdef0011223344556677};
        foreach (vt[i]) begin
            aes_real = vt[i].real_aes;
            if (vt[i].load) do_cfg(vt[i].mode, vt[i].enc, vt[i].iv);
            cin_q.delete(); cenc_q.delete();
            run_block(vt[i].x, 0, got, lat);
            chk($sformatf("vec%0d_out", i), got, vt[i].exp_out);
            chk($sformatf("vec%0d_iv", i), dut.iv_q, vt[i].exp_iv);
            chk($sformatf("vec%0d_cin", i), cin_q.size() > 0 ? cin_q[0] : 'x, vt[i].exp_cin);
            if (i == 0) chk("vec0_latency", lat, 3);
        end
        aes_real = 0;
        chk("mode_err_set", bus.mode_err, 1);

        // ---- cfg and data offered together: cfg wins ----
        s0 = n_s;
        @(negedge clk);
        bus.cfg_valid = 1; bus.cfg_mode = MODE_CBC; bus.cfg_encrypt = 1; bus.cfg_iv = {4{32'h5a5a0f0f}};
        bus.s_valid = 1; bus.s_data = 128'h1;
        #1;
        chk("both_s_ready_low", bus.s_ready, 0);
        chk("both_cfg_ready", bus.cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 0; bus.s_valid = 0;
        chk("both_no_s_hs", n_s - s0, 0);
        miv = {4{32'h5a5a0f0f}};
        x = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        model(MODE_CBC, 1, miv, x, eo, ec, ece);
        run_block(x, 0, got, lat);
        chk("both_out", got, eo);
        chk("both_iv", dut.iv_q, miv);

        // ---- backpressure on core_in_ready and m_ready ----
        run_block(128'h77, 0, got, lat0);
        model(MODE_CBC, 1, miv, 128'h77, eo, ec, ece);
        chk("bp_base_latency", lat0, 3);
        chk("bp_base_out", got, eo);
        ci_stall = 5;
        s0 = n_s; ci0 = n_cin; co0 = n_cout; m0 = n_m; st0 = stab_err;
        x = 128'hfeedface_0badc0de_13579bdf_2468ace0;
        model(MODE_CBC, 1, miv, x, eo, ec, ece);
        run_block(x, 4, got, lat);
        ci_stall = 0;
        chk("bp_latency", lat, 12);
        chk("bp_out", got, eo);
        chk("bp_stable", stab_err - st0, 0);
        chk("bp_one_s", n_s - s0, 1);
        chk("bp_one_cin", n_cin - ci0, 1);
        chk("bp_one_cout", n_cout - co0, 1);
        chk("bp_one_m", n_m - m0, 1);

        // ---- randomized modes against the reference model ----
        for (int trial = 0; trial < 25; trial++) begin
            logic [2:0] m;
            bit e;
            int nb;
            m = 3'($urandom_range(0, 5));
            e = 1'($urandom_range(0, 1));
            riv = {$urandom, $urandom, $urandom, $urandom};
            if (m == MODE_CTR && trial[0]) riv[31:0] = 32'hffffffff;
            do_cfg(m, e, riv);
            miv = riv;
            nb = $urandom_range(1, 3);
            ci_stall = $urandom_range(0, 2);
            core_lat = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                model(m, e, miv, x, eo, ec, ece);
                cin_q.delete(); cenc_q.delete();
                run_block(x, $urandom_range(0, 2), got, lat);
                chk($sformatf("rnd%0d_%0d_m%0d_out", trial, b, m), got, eo);
                chk($sformatf("rnd%0d_%0d_m%0d_cin", trial, b, m), cin_q.size() > 0 ? cin_q[0] : 'x, ec);
                chk($sformatf("rnd%0d_%0d_m%0d_cenc", trial, b, m), cenc_q.size() > 0 ? cenc_q[0] : 1'bx, ece);
                chk($sformatf("rnd%0d_%0d_m%0d_iv", trial, b, m), dut.iv_q, miv);
            end
        end
        ci_stall = 0; core_lat = 0;
        chk("rnd_stable", stab_err, 0);

        // ---- reset in CORE_WAIT abandons the block ----
        do_cfg(MODE_CBC, 1, 128'h1234);
        core_lat = 8;
        m0 = n_m; co0 = n_cout;
        @(negedge clk);
        bus.s_valid = 1; bus.s_data = 128'hab;
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 0;
        lat = 0;
        while (!bus.core_out_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("rst_reach_wait", bus.core_out_ready, 1);
        #2 reset = 1;
        #1;
        chk("rst2_cfg_ready", bus.cfg_ready, 1);
        chk("rst2_core_out_ready", bus.core_out_ready, 0);
        chk("rst2_iv", dut.iv_q, 0);
        chk("rst2_mode_err", bus.mode_err, 0);
        @(negedge clk);
        reset = 0; abort = 1;
        mv = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.m_valid) mv = 1;
        end
        abort = 0;
        chk("rst2_no_m_valid", mv, 0);
        chk("rst2_no_m_hs", n_m - m0, 0);
        chk("rst2_no_cout_hs", n_cout - co0, 0);
        core_lat = 0;
        x = 128'h5555aaaa;
        run_block(x, 0, got, lat);
        chk("rst2_ecb_after", got, x ^ A5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/aes_chain_unit.md
# aes_chain_unit

- Sequential block-cipher mode engine that sits between the AXI-stream block path and the AES core.
- Supports ECB, CBC, PCBC, CFB, OFB and CTR:
  - holds the chaining IV register;
  - drives the core through a valid/ready handshake;
  - applies the pre- and post-core XORs for the selected mode;
  - updates the IV after every block.
- It generalises the combinational PCBC next-state logic into a parametrised, stateful, multi-mode unit with one block in flight.

## Interface

Parameters:
- `BLK_S`, 128: block width in bits; `IV_BITS` equals `BLK_S`.
- `CTR_W`, 32: CTR-mode counter width, the low bits of the IV.

Ports:
- One clock; reset is asynchronous and active-high.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `cfg_valid`  in  1: load mode, direction and IV.
- `cfg_ready`  out  1: high only in IDLE.
- `cfg_mode`  in  3: mode code. 0 ECB, 1 CBC, 2 PCBC, 3 CFB, 4 OFB, 5 CTR.
- `cfg_encrypt`  in  1: 1 = encrypt, 0 = decrypt.
- `cfg_iv`  in  `BLK_S`: initial IV or counter block.
- `s_valid` / `s_ready` / `s_data`  in / out / in  1 / 1 / `BLK_S`: input block.
- `core_in_valid` / `core_in_ready` / `core_in_data`  out / in / out  1 / 1 / `BLK_S`: request to the AES core.
- `core_encrypt`  out  1: core direction.
- `core_out_valid` / `core_out_ready` / `core_out_data`  in / out / in  1 / 1 / `BLK_S`: result from the AES core.
- `m_valid` / `m_ready` / `m_data`  out / in / out  1 / 1 / `BLK_S`: output block.
- `mode_err`  out  1: sticky; set by a cfg load with mode code 6 or 7.

## Operation

FSM states: IDLE, CORE_REQ, CORE_WAIT, OUT.

IDLE:
- `cfg_ready` = 1 and `s_ready` = 1, except `s_ready` is 0 when `cfg_valid` = 1. Config has priority over data.
- cfg handshake: latch mode, direction and IV.
  - Mode code 6 or 7: latch ECB and set `mode_err`.
- s handshake: latch `s_data` into `in_q`, then go to CORE_REQ.

CORE_REQ:
- `core_in_valid` = 1; `core_in_data` is held stable.
- On `core_in_ready`, go to CORE_WAIT.

CORE_WAIT:
- `core_out_ready` = 1.
- On `core_out_valid`, compute the output and the next IV, register both, and go to OUT.

OUT:
- `m_valid` = 1 and `m_data` is held stable.
- On `m_ready`, go to IDLE.

Datapath. X = `in_q`, Y = `core_out_data`, I = IV:
- ECB: core X; out Y; IV unchanged. `core_encrypt` = encrypt.
- CBC encrypt: core X^I; out Y; IV = Y.
- CBC decrypt: core X; out Y^I; IV = X.
- PCBC encrypt: core X^I; out Y; IV = X^Y.
- PCBC decrypt: core X; out Y^I; IV = X^out.
- CFB: core I; out Y^X. IV = out when encrypting, X when decrypting.
- OFB: core I; out Y^X; IV = Y.
- CTR: core I; out Y^X. IV low `CTR_W` bits incremented modulo 2^`CTR_W` with wrap; upper bits unchanged.
- CFB, OFB and CTR always drive `core_encrypt` = 1.
- `core_in_data` is registered on entry to CORE_REQ.

Reset behaviour:
- State goes to IDLE.
- IV, `in_q`, `m_data` and `core_in_data` go to 0.
- Mode goes to ECB, direction to encrypt, `mode_err` to 0.
- All valid and ready outputs go to 0, except `cfg_ready` and `s_ready` = 1.
- Reset mid-operation abandons the in-flight block and drives no output; `core_out_valid` arriving later is ignored in IDLE.

## Timing

- s handshake at edge N: `core_in_valid` is high from cycle N+1.
- Core acceptance at edge M: `core_out_ready` is high from M+1.
- `core_out_valid` at edge K: `m_valid` is high from K+1.
- Minimum latency is 3 cycles plus the core latency. Throughput is one block per (core latency + 3) cycles or more.
- The IV update is visible at the same edge `m_valid` rises; a cfg load in the following IDLE overrides it.
- Held-off handshakes (`core_in_ready` = 0, `m_ready` = 0): data stays stable indefinitely.
- `cfg_valid` outside IDLE is ignored, since `cfg_ready` = 0.

## Structure

Shared `aes_pkg`:
- mode code localparams: `MODE_ECB` … `MODE_CTR`;
- FSM state enum;
- the `BLK_S` / `IV_BITS` defaults.

Sub-module `chain_xor`:
- combinational; inputs mode, direction, X, Y, I;
- outputs the core input select, `m_data` and IV next.
- Keeps the FSM file free of datapath equations.

## Test plan

1. Real AES-128 core, key `2b7e151628aed2a6abf7158809cf4f3c`, CBC encrypt, IV `000102030405060708090a0b0c0d0e0f`. Input P `6bc1bee22e409f96e93d7e117393172a` → `m_data` = `7649abac8119b246cee98e9b12e9197d`; next IV equals that value.
2. Stub core Y = input ^ {16{`a5`}}, PCBC encrypt, IV 0, two blocks of all-`11`. Block 1 out = {16{`b4`}}, IV = {16{`a5`}}. Block 2 out = {16{`11`}}.
3. CTR, IV low word `ffffffff`, upper `00…01`, three blocks. IV wraps to low word 0, upper `00…01` unchanged, then low word 1; the core sees each value in turn.
4. Backpressure: `core_in_ready` held 0 for 5 cycles, `m_ready` held 0 for 4 cycles. `core_in_data` and `m_data` stay stable, there are no duplicate handshakes, and total latency grows by 9.
5. `cfg_valid` and `s_valid` in the same IDLE cycle → `s_ready` = 0 and the cfg is accepted. Later, a cfg with mode 7 → `mode_err` = 1 and ECB behaviour: out = Y.
6. Assert `reset` while in CORE_WAIT → asynchronous return to IDLE, IV = 0, `m_valid` never rises; a late `core_out_valid` produces no output.
